// File: rtl/hex_line_pkg.sv
// Shared definitions for the hex line assembler.
// Holds the line-parser state encoding and the ASCII control characters
// that the character classifier and the assembler both recognise.
package hex_line_pkg;

    // Parser states: waiting for a first digit, collecting digits,
    // throwing a bad line away, and holding a finished word for the consumer
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_QM = 8'h3F;

endpackage

// File: rtl/hex_char_class.sv
// Combinational ASCII character classifier for the hex line assembler.
// Ports:
//   rx_data  - received ASCII byte
//   is_digit - byte is 0-9, A-F or a-f
//   is_term  - byte is CR or LF
//   is_bs    - byte is backspace
//   is_sp    - byte is a space
//   nib      - hex value of the byte (meaningful only when is_digit is high)
module hex_char_class
    import hex_line_pkg::*;
(
    input  logic [7:0] rx_data,
    output logic       is_digit,
    output logic       is_term,
    output logic       is_bs,
    output logic       is_sp,
    output logic [3:0] nib
);

    logic is_num;
    logic is_upper;
    logic is_lower;

    // Decode the byte into its class; letters carry their value in the low
    // nibble offset by 9 ('A' = 0x41 -> 1 + 9 = 10) for both cases
    always_comb begin
        is_num   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_upper = (rx_data >= 8'h41) && (rx_data <= 8'h46);
        is_lower = (rx_data >= 8'h61) && (rx_data <= 8'h66);
        is_digit = is_num || is_upper || is_lower;
        is_term  = (rx_data == CH_CR) || (rx_data == CH_LF);
        is_bs    = (rx_data == CH_BS);
        is_sp    = (rx_data == CH_SP);
        nib      = is_num ? rx_data[3:0] : (rx_data[3:0] + 4'd9);
    end

endmodule

// File: rtl/hex_line_assembler.sv
// Hex line assembler: collects ASCII hex digits from a byte stream into a
// binary word (most significant digit first) and hands the word to a
// consumer with a valid/ready handshake when a CR or LF ends the line.
// Lines with illegal characters or too many digits are dropped and flagged
// with a one-cycle err pulse when their terminator arrives.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   rx_data, rx_valid    - incoming ASCII byte and its qualifier
//   rx_ready             - byte accepted when rx_valid && rx_ready
//   word, ndig           - assembled value (right-justified) and digit count
//   word_valid           - word/ndig valid, held until word_ready
//   word_ready           - consumer takes the word
//   err                  - one-cycle pulse when a line is discarded
// Optional build macro HEX_LINE_ECHO_EN adds:
//   echo_data, echo_valid - echo of each accepted byte one cycle later,
//                           illegal bytes shown as '?'
module hex_line_assembler
    import hex_line_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [7:0]                         rx_data,
    input  logic                               rx_valid,
    output logic                               rx_ready,
    output logic [4*NDIGITS-1:0]               word,
    output logic [$clog2(NDIGITS+1)-1:0]       ndig,
    output logic                               word_valid,
    input  logic                               word_ready,
    output logic                               err
`ifdef HEX_LINE_ECHO_EN
    ,
    output logic [7:0]                         echo_data,
    output logic                               echo_valid
`endif
);

    localparam int W  = 4 * NDIGITS;
    localparam int NW = $clog2(NDIGITS + 1);
    localparam logic [NW-1:0] NDIG_MAX = NW'(NDIGITS);

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    word_nxt;
    logic [NW-1:0]   ndig_nxt;
    logic            err_nxt;
    logic            take;
    logic            is_illegal;

    logic            is_digit;
    logic            is_term;
    logic            is_bs;
    logic            is_sp;
    logic [3:0]      nib;

    hex_char_class u_class (
        .rx_data  (rx_data),
        .is_digit (is_digit),
        .is_term  (is_term),
        .is_bs    (is_bs),
        .is_sp    (is_sp),
        .nib      (nib)
    );

    // Handshake outputs come straight from the state; rx_ready is gated by
    // rst_n so it drops immediately when reset is asserted
    always_comb begin
        rx_ready   = rst_n && (state != DONE);
        word_valid = (state == DONE);
        take       = rx_valid && rx_ready;
        is_illegal = !(is_digit || is_term || is_bs || is_sp);
    end

    // Next-state logic. The word is only ever shifted while accumulating;
    // in DISCARD the partial value is left alone and cleared together with
    // ndig when the terminator closes the bad line
    always_comb begin
        state_nxt = state;
        word_nxt  = word;
        ndig_nxt  = ndig;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    if (is_digit) begin
                        word_nxt  = W'(nib);
                        ndig_nxt  = NW'(1);
                        state_nxt = ACCUM;
                    end else if (is_illegal) begin
                        state_nxt = DISCARD;
                    end
                end
            end
            ACCUM: begin
                if (take) begin
                    if (is_digit) begin
                        if (ndig == NDIG_MAX) begin
                            state_nxt = DISCARD;
                        end else begin
                            word_nxt = (word << 4) | W'(nib);
                            ndig_nxt = ndig + NW'(1);
                        end
                    end else if (is_bs) begin
                        word_nxt = word >> 4;
                        ndig_nxt = ndig - NW'(1);
                        if (ndig == NW'(1)) begin
                            state_nxt = IDLE;
                        end
                    end else if (is_term) begin
                        state_nxt = DONE;
                    end else if (is_illegal) begin
                        state_nxt = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (take && is_term) begin
                    err_nxt   = 1'b1;
                    word_nxt  = '0;
                    ndig_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                if (word_ready) begin
                    word_nxt  = '0;
                    ndig_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                word_nxt  = '0;
                ndig_nxt  = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial line silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            word  <= '0;
            ndig  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            word  <= word_nxt;
            ndig  <= ndig_nxt;
            err   <= err_nxt;
        end
    end

`ifdef HEX_LINE_ECHO_EN
    // Echo every accepted byte one cycle later so a terminal user sees what
    // was typed; bytes the parser cannot use are shown as '?'
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_data  <= 8'h00;
            echo_valid <= 1'b0;
        end else begin
            echo_valid <= take;
            if (take) begin
                echo_data <= is_illegal ? CH_QM : rx_data;
            end
        end
    end
`endif

endmodule

// File: doc/hex_line_assembler.md
Name: hex_line_assembler

Overview:
- Line parser that sits directly upstream of the ASCII-hex nibble conversion path in the UART command chain.
- Accepts received ASCII bytes one at a time and filters out non-hex characters.
- Shifts hex digits into a binary word, most significant digit first.
- On a line terminator, presents the assembled word with a valid/ready handshake to the command consumer.

Parameters:
- NDIGITS, 4, maximum hex digits per line; the output word is 4*NDIGITS bits wide.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received ASCII byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  block can accept a byte; a byte is consumed when rx_valid && rx_ready.
- word  output  4*NDIGITS  assembled value, right-justified and zero-extended.
- ndig  output  clog2(NDIGITS+1)  number of digits in word.
- word_valid  output  1  word/ndig are valid; held until taken.
- word_ready  input  1  consumer takes the word when word_valid && word_ready.
- err  output  1  one-cycle pulse when a line is discarded.

Behaviour:
- Reset values (async, rst_n low): rx_ready=0, word=0, ndig=0, word_valid=0, err=0, state=IDLE.
- rx_ready is 1 in IDLE, ACCUM and DISCARD; it is 0 in DONE and during reset.
- Character classes:
  - digit: 0x30-0x39, 0x41-0x46, 0x61-0x66.
  - terminator: 0x0D or 0x0A.
  - backspace: 0x08.
  - space: 0x20.
  - anything else: illegal.
- IDLE:
  - digit -> word={word<<4 | nib}, ndig=1, go to ACCUM.
  - terminator / space / backspace -> ignored, stay in IDLE (empty lines produce no output).
  - illegal -> go to DISCARD.
- ACCUM:
  - digit with ndig<NDIGITS -> shift in the nibble, ndig++.
  - digit with ndig==NDIGITS -> overflow, go to DISCARD.
  - backspace -> word=word>>4, ndig--; if ndig becomes 0, go to IDLE.
  - space -> ignored.
  - terminator -> go to DONE, word_valid=1 on the next cycle (latency: 1 cycle after terminator acceptance).
  - illegal -> go to DISCARD.
- DISCARD:
  - All bytes are consumed and dropped until a terminator.
  - On the terminator: err pulses for 1 cycle, word=0, ndig=0, go to IDLE.
- DONE:
  - word_valid held high; word and ndig stable.
  - On word_ready: word_valid=0, word=0, ndig=0, go to IDLE in the following cycle.
  - rx bytes are stalled (rx_ready=0) while in DONE.
- word is always cleared when entering IDLE from DONE or DISCARD.
- Nibble decode:
  - 0-9 -> rx_data[3:0].
  - A-F / a-f -> rx_data[3:0]+9.
- Reset asserted mid-line or in DONE: everything clears immediately; any partial line is lost with no err pulse.

Optional Feature:
- Macro: HEX_LINE_ECHO_EN.
- When defined, two extra outputs are added: echo_data[7:0] and echo_valid.
  - Every accepted byte except illegal bytes is echoed, with echo_valid high exactly one cycle after acceptance. Illegal bytes are echoed as 0x3F ('?').
  - Backspace is echoed as 0x08.
  - Both outputs reset to 0.
- When undefined: the ports do not exist, and the core behaviour is identical.

Decomposition:
- Shared package hex_line_pkg holds:
  - the state enum (IDLE, ACCUM, DISCARD, DONE);
  - character constants CH_CR=8'h0D, CH_LF=8'h0A, CH_BS=8'h08, CH_SP=8'h20, CH_QM=8'h3F.
- One natural sub-module, hex_char_class: combinational; maps rx_data to {is_digit, is_term, is_bs, is_sp, nib[3:0]}.

Test Plan:
- "1A3f\r" with word_ready=1 -> word=16'h1A3F, ndig=3'd4, word_valid high 1 cycle after the CR.
- "12345\r" with NDIGITS=4 -> overflow at '5', DISCARD; err pulse after the CR; no word_valid.
- "7 b\x08c\n" -> space ignored, backspace removes b; word=16'h007C, ndig=2.
- "\r\r" -> no word_valid, no err; "z9\r" -> err pulse, word stays 0.
- Hold word_ready=0 after "ff\r", then drive "1\r" -> rx_ready=0 and word=16'h00FF stable; after word_ready, the second line yields 16'h0001.
- Assert rst_n low mid-line after "ab" -> all outputs 0; then "5\r" -> word=16'h0005.
